// File: rtl/touch_screen_ccc_pkg.sv
// Shared types for the fabric clock-conditioning block:
// channel state, channel config and the reset config.
package touch_screen_ccc_pkg;

  localparam int CCC_DIV_W = 5;
  localparam int CCC_DLY_W = 5;

  typedef enum logic [1:0] {
    ST_BYP,
    ST_DELAY,
    ST_RUN
  } ch_state_e;

  typedef struct packed {
    logic [CCC_DIV_W-1:0] div;
    logic [CCC_DLY_W-1:0] dly;
    logic                 bypass;
  } ccc_cfg_t;

  localparam ccc_cfg_t CFG_RST = '{
    div:    '0,
    dly:    '0,
    bypass: 1'b1
  };

endpackage

// File: rtl/touch_screen_fab_ccc_if.sv
// Channel write port: one-cycle write strobe plus
// the registered acknowledge pulse.
interface touch_screen_fab_ccc_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 5,
  parameter int DLY_W = 5
) ();

  logic             WR_EN;
  logic [CH_W-1:0]  WR_CH;
  logic [DIV_W-1:0] WR_DIV;
  logic [DLY_W-1:0] WR_DLY;
  logic             WR_BYPASS;
  logic             WR_ACK;

  modport master (
    output WR_EN, WR_CH, WR_DIV,
    output WR_DLY, WR_BYPASS,
    input  WR_ACK
  );

  modport slave (
    input  WR_EN, WR_CH, WR_DIV,
    input  WR_DLY, WR_BYPASS,
    output WR_ACK
  );

endinterface

// File: rtl/touch_screen_ccc_chan.sv
// One output channel: pending/active config, BYP/DELAY/RUN
// sequencing and CE/GL decode. New configs land only at terminal count.
module touch_screen_ccc_chan
  import touch_screen_ccc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr,
  input  ccc_cfg_t wr_cfg,
  output logic     ce,
  output logic     gl,
  output logic     apply,
  output logic     pend
);

  ch_state_e            state_q, state_d;
  logic [CCC_DIV_W-1:0] cnt_q, cnt_d;
  logic [CCC_DLY_W-1:0] dcnt_q, dcnt_d;
  // dly/bypass are consumed at the apply point,
  // so only the divider survives in the active set
  logic [CCC_DIV_W-1:0] div_q, div_d;
  ccc_cfg_t             pnd_q, pnd_d;
  logic                 pflag_q, pflag_d;

  // apply point, state sequencing and pending capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    div_d   = div_q;
    pnd_d   = pnd_q;
    pflag_d = pflag_q;
    apply   = pflag_q &&
              ((state_q != ST_RUN) || (cnt_q == div_q));
    if (apply) begin
      pflag_d = 1'b0;
      div_d   = pnd_q.div;
      cnt_d   = '0;
      if (pnd_q.bypass) begin
        state_d = ST_BYP;
      end else if (pnd_q.dly == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DELAY;
        dcnt_d  = pnd_q.dly;
      end
    end else begin
      case (state_q)
        ST_DELAY: begin
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q == CCC_DLY_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = (cnt_q == div_q) ? '0
                                   : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
    // a write coinciding with apply becomes the next pending
    if (wr) begin
      pnd_d   = wr_cfg;
      pflag_d = 1'b1;
    end
  end

  // channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BYP;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      div_q   <= CFG_RST.div;
      pnd_q   <= CFG_RST;
      pflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      div_q   <= div_d;
      pnd_q   <= pnd_d;
      pflag_q <= pflag_d;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    ce   = (state_q == ST_BYP) ||
           ((state_q == ST_RUN) && (cnt_q == div_q));
    gl   = (state_q == ST_RUN) && (cnt_q <= (div_q >> 1));
    pend = pflag_q;
  end

endmodule

// File: rtl/touch_screen_fab_ccc.sv
// Fabric CCC top: write decode, WR_ACK, channel array, LOCK.
// TOUCH_SCREEN_FAB_CCC_LOCK_EN builds the stability lock counter.
module touch_screen_fab_ccc
  import touch_screen_ccc_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = CCC_DIV_W,
  parameter int DLY_W       = CCC_DLY_W,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  touch_screen_fab_ccc_if.slave bus,
  output logic [NUM_CH-1:0]     CE,
  output logic [NUM_CH-1:0]     GL,
  output logic                  LOCK
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DIV_W-1:0]  wr_div;
  logic [DLY_W-1:0]  wr_dly;
  logic              wr_ok;
  logic              wr_ack_q, wr_ack_d;
  ccc_cfg_t          wr_cfg;
  logic [NUM_CH-1:0] apply_v;
  logic [NUM_CH-1:0] pend_v;

  assign wr_div = bus.WR_DIV;
  assign wr_dly = bus.WR_DLY;

  // write qualification: out-of-range channels are dropped
  always_comb begin
    wr_ok         = bus.WR_EN &&
                    (32'(bus.WR_CH) < NUM_CH);
    wr_ack_d      = wr_ok;
    wr_cfg.div    = CCC_DIV_W'(wr_div);
    wr_cfg.dly    = CCC_DLY_W'(wr_dly);
    wr_cfg.bypass = bus.WR_BYPASS;
  end

  // write acknowledge pulse
  always_ff @(posedge CLK) begin
    if (RESET) wr_ack_q <= 1'b0;
    else       wr_ack_q <= wr_ack_d;
  end

  assign bus.WR_ACK = wr_ack_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    touch_screen_ccc_chan u_chan (
      .clk    (CLK),
      .rst    (RESET),
      .wr     (wr_ok && (bus.WR_CH == CH_W'(i))),
      .wr_cfg (wr_cfg),
      .ce     (CE[i]),
      .gl     (GL[i]),
      .apply  (apply_v[i]),
      .pend   (pend_v[i])
    );
  end

`ifdef TOUCH_SCREEN_FAB_CCC_LOCK_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [LW-1:0] lcnt_q, lcnt_d;

  // stability counter: restarts on any apply or pending write
  always_comb begin
    lcnt_d = lcnt_q;
    if ((|apply_v) || (|pend_v)) begin
      lcnt_d = '0;
    end else if (lcnt_q != LW'(LOCK_CYCLES)) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  // lock counter register
  always_ff @(posedge CLK) begin
    if (RESET) lcnt_q <= '0;
    else       lcnt_q <= lcnt_d;
  end

  assign LOCK = (lcnt_q == LW'(LOCK_CYCLES));
`else
  logic lock_q, lock_d;
  logic lock_unused;

  // without the counter LOCK only tracks reset release
  always_comb begin
    lock_d      = 1'b1;
    lock_unused = ^{apply_v, pend_v};
  end

  // lock flag register
  always_ff @(posedge CLK) begin
    if (RESET) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign LOCK = lock_q;
`endif

endmodule

// File: tb/tb_touch_screen_fab_ccc.sv
// Bench for touch_screen_fab_ccc: directed literal checks plus
// randomized writes/resets against a cycle-level behavioural model.
module tb_touch_screen_fab_ccc;

  localparam int NCH = 3;
`ifdef TOUCH_SCREEN_FAB_CCC_LOCK_EN
  localparam int LOCK_LAT = 16;
`else
  localparam int LOCK_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] ce, gl;
  logic lock;

  always #5 clk = ~clk;

  touch_screen_fab_ccc_if #(
    .CH_W(2), .DIV_W(5), .DLY_W(5)
  ) bus ();

  touch_screen_fab_ccc #(
    .NUM_CH(NCH), .DIV_W(5), .DLY_W(5), .LOCK_CYCLES(16)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus),
    .CE   (ce),
    .GL   (gl),
    .LOCK (lock)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // model: mode 0 = bypass, 1 = waiting out delay, 2 = running
  int m_mode[NCH];
  int m_div[NCH];
  int m_cnt[NCH];
  int m_left[NCH];
  int p_div[NCH];
  int p_dly[NCH];
  int p_byp[NCH];
  bit p_f[NCH];
  bit m_ack;
  int m_stable;
  bit m_lock;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model advance on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_div[c] = 0; m_cnt[c] = 0;
        m_left[c] = 0; p_f[c] = 0;
      end
      m_ack = 0; m_stable = 0; m_lock = 0;
    end else begin
      bit busy;
      busy = 0;
      for (int c = 0; c < NCH; c++) begin
        bit ap;
        busy |= p_f[c];
        ap = p_f[c] &&
             (m_mode[c] != 2 || m_cnt[c] == m_div[c]);
        if (ap) begin
          p_f[c] = 0;
          m_div[c] = p_div[c];
          m_cnt[c] = 0;
          if (p_byp[c] != 0) m_mode[c] = 0;
          else if (p_dly[c] == 0) m_mode[c] = 2;
          else begin
            m_mode[c] = 1;
            m_left[c] = p_dly[c];
          end
        end else if (m_mode[c] == 1) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_mode[c] = 2; m_cnt[c] = 0;
          end
        end else if (m_mode[c] == 2) begin
          m_cnt[c] = (m_cnt[c] + 1) % (m_div[c] + 1);
        end
        if (bus.WR_EN && int'(bus.WR_CH) == c) begin
          p_div[c] = int'(bus.WR_DIV);
          p_dly[c] = int'(bus.WR_DLY);
          p_byp[c] = int'(bus.WR_BYPASS);
          p_f[c] = 1;
        end
      end
      m_ack = bus.WR_EN && int'(bus.WR_CH) < NCH;
`ifdef TOUCH_SCREEN_FAB_CCC_LOCK_EN
      if (busy) m_stable = 0;
      else if (m_stable < 16) m_stable++;
      m_lock = (m_stable == 16);
`else
      m_lock = 1;
`endif
    end
  end

  // compare process: every cycle once the model is seeded
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NCH-1:0] e_ce, e_gl;
      for (int c = 0; c < NCH; c++) begin
        e_ce[c] = (m_mode[c] == 0) ||
                  (m_mode[c] == 2 && m_cnt[c] == m_div[c]);
        // high for ceil(R/2) cycles of the R-cycle period
        e_gl[c] = (m_mode[c] == 2) &&
                  (m_cnt[c] < (m_div[c] + 2) / 2);
      end
      check("ce", int'(ce), int'(e_ce));
      check("gl", int'(gl), int'(e_gl));
      check("lock", int'(lock), int'(m_lock));
      check("ack", int'(bus.WR_ACK), int'(m_ack));
    end
  end

  // called just after a falling edge; returns in the ack cycle
  task automatic wr(int ch, int dv, int dl, int bp, int exp_ack);
    bus.WR_EN = 1'b1;
    bus.WR_CH = 2'(ch);
    bus.WR_DIV = 5'(dv);
    bus.WR_DLY = 5'(dl);
    bus.WR_BYPASS = 1'(bp);
    @(negedge clk);
    check("wr_ack_lit", int'(bus.WR_ACK), exp_ack);
    #1 bus.WR_EN = 1'b0;
  endtask

  initial begin
    logic [7:0] v8, g8;
    logic [9:0] v10, g10;
    int n;
    rst = 1'b1;
    bus.WR_EN = 1'b0;
    bus.WR_CH = '0;
    bus.WR_DIV = '0;
    bus.WR_DLY = '0;
    bus.WR_BYPASS = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("rst_ce", int'(ce), 7);
    check("rst_gl", int'(gl), 0);
    check("rst_lock", int'(lock), 0);
    check("rst_ack", int'(bus.WR_ACK), 0);
    #1 rst = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lock && n < 40);
    check("lock_latency", n, LOCK_LAT);
    #1;

    wr(1, 3, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v8[i] = ce[1];
      g8[i] = gl[1];
    end
    check("ch1_ce_pat", int'(v8), 8'b1000_1000);
    check("ch1_gl_pat", int'(g8), 8'b0011_0011);
    #1;

    wr(0, 4, 5, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v10[i] = ce[0];
      g10[i] = gl[0];
    end
    check("ch0_ce_dly", int'(v10), 10'b10_0000_0000);
    check("ch0_gl_dly", int'(g10), 10'b00_1110_0000);
    #1;

    wr(2, 7, 0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    wr(2, 1, 0, 0, 1);
    #1;
    wr(1, 5, 0, 0, 1);
    #1;
    wr(1, 2, 0, 0, 1);
    #1;
    wr(3, 9, 1, 0, 0);
    repeat (20) @(negedge clk);
    #1;

    for (int k = 0; k < 3000; k++) begin
      if ((k % 500) >= 440) begin
        bus.WR_EN = 1'b0;
      end else begin
        bus.WR_EN = ($urandom_range(0, 5) == 0);
        bus.WR_CH = 2'($urandom_range(0, 3));
        bus.WR_DIV = ($urandom_range(0, 3) == 0) ?
                     5'($urandom_range(0, 31)) :
                     5'($urandom_range(0, 7));
        bus.WR_DLY = 5'($urandom_range(0, 6));
        bus.WR_BYPASS = ($urandom_range(0, 4) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      #1;
    end
    bus.WR_EN = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;

    wr(0, 3, 6, 0, 1);
    repeat (2) @(negedge clk);
    check("mid_dly_ce0", int'(ce[0]), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ce", int'(ce), 7);
    check("mid_rst_gl", int'(gl), 0);
    check("mid_rst_lock", int'(lock), 0);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
